cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) between the result producers of the out-of-order core: ALU reservation station, load/store buffer, branch unit.
- Each cycle it picks at most one pending result by round-robin, acknowledges it, and broadcasts {tag, data} one cycle later on the registered CDB.
- The registered CDB is read by every reservation station, the load/store buffer and the register file.
- Replaces per-unit private result buses; RS entries then snoop a single bus.

Parameters:
- NREQ, 3, number of requesters (index 0 = ALU, 1 = LSBuf, 2 = branch).
- TAG_W, 4, tag width; tag value 0 is the free tag (tagFree).
- DATA_W, 32, result data width.
- SRC_W, 2, width of the source index; must satisfy 2^SRC_W >= NREQ.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous pipeline flush (branch mispredict).
- req_valid  in  NREQ  requester i holds a result.
- req_tag  in  NREQ*TAG_W  tag of requester i, at slice [i*TAG_W +: TAG_W].
- req_data  in  NREQ*DATA_W  data of requester i, at slice [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  one-hot grant, combinational, same cycle as the accepted request.
- cdb_valid  out  1  registered CDB valid.
- cdb_tag  out  TAG_W  registered CDB tag.
- cdb_data  out  DATA_W  registered CDB data.
- cdb_src  out  SRC_W  index of the requester that produced the broadcast.

Behaviour:
- Reset (rst low, asynchronous):
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, priority pointer ptr=0.
  - req_ready=0 while rst is low.
- Requester handshake:
  - req_valid[i] with stable tag/data is held until a cycle where req_ready[i]=1.
  - The transfer completes on that rising edge.
  - Requesters must not withdraw a request before it is granted; behaviour is undefined if they do.
- Grant selection (combinational):
  - Search req_valid from index ptr upward, wrapping modulo NREQ.
  - The first set bit wins; req_ready is one-hot or zero.
  - req_ready=0 whenever flush=1.
- Pointer update on the grant edge: ptr <= (winner+1) mod NREQ. Unchanged when there is no grant.
- Broadcast latency: 1 cycle.
  - Grant at edge k gives cdb_valid=1 with winner tag/data/src during cycle k+1.
  - cdb_valid is high for exactly one cycle per grant.
  - Back-to-back grants give a continuous cdb_valid with a new tag every cycle.
- No grant at an edge: cdb_valid <= 0; cdb_tag/cdb_data/cdb_src keep their previous values.
- Free-tag request (granted req_tag==0):
  - The request is acknowledged (req_ready=1) and discarded: cdb_valid <= 0.
  - ptr still advances.
- Flush at an edge:
  - No grant, cdb_valid <= 0, ptr <= 0.
  - Pending requests stay asserted by their owners and compete from the next cycle.
  - A broadcast already registered during the flush cycle remains visible that cycle.
- Reset mid-operation: any in-flight broadcast is dropped immediately (asynchronous), ptr returns to 0.
- Throughput: one result per cycle. With all requesters continuously valid, each is granted once every NREQ cycles (no starvation).

Test Plan:
- Reset then idle: rst low for 2 cycles, release, all req_valid=0 for 5 cycles -> cdb_valid=0, cdb_tag=0, cdb_data=0, req_ready=0 throughout.
- Single requester: req_valid=3'b010, tag=5, data=0x1234 at cycle 1 -> req_ready=3'b010 in cycle 1; cdb_valid=1, tag=5, data=0x1234, src=1 in cycle 2; cdb_valid=0 in cycle 3.
- Round-robin fairness: all three requesters valid with tags 1/2/3, each reloading with a new tag after its grant, for 6 cycles -> grant order 0,1,2,0,1,2; cdb_valid continuous from cycle 2.
- Free tag: req_valid=3'b001 with tag=0, data=0xFF -> req_ready[0]=1; next cycle cdb_valid=0; ptr=1, so a later simultaneous request on 0 and 1 is granted to 1 first.
- Flush: ptr=2, req_valid=3'b111, flush=1 for one cycle -> req_ready=0 that cycle; next cycle cdb_valid=0, then requester 0 is granted (ptr reset to 0).
- Asynchronous reset mid-broadcast: drive rst low mid-cycle while cdb_valid=1 -> cdb_valid drops immediately, without waiting for a clock edge; after release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among result producers
// (0 = ALU RS, 1 = load/store buffer, 2 = branch unit) and a registered
// {tag, data, src} broadcast one cycle after the grant.
module cdb_arbiter #(
  parameter int NREQ   = 3,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int SRC_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic [SRC_W-1:0]         cdb_src
);

  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  logic [TAG_W-1:0]  tag_arr  [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];
  logic [SRC_W:0]    rr_sum;
  logic [SRC_W-1:0]  rr_idx;
  logic [SRC_W-1:0]  win_idx;
  logic              win_found;
  logic              grant_en;
  logic [TAG_W-1:0]  win_tag;
  logic [DATA_W-1:0] win_data;

  // Unpack the flat request buses into per-requester slices
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      tag_arr[i]  = req_tag[i*TAG_W +: TAG_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search from ptr upward; scanning offsets high-to-low lets the
  // nearest valid requester (smallest offset) overwrite the others
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, ptr_q} + (SRC_W+1)'(k);
      if (rr_sum >= (SRC_W+1)'(NREQ)) begin
        rr_sum = rr_sum - (SRC_W+1)'(NREQ);
      end
      rr_idx = rr_sum[SRC_W-1:0];
      if (req_valid[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = rr_idx;
      end
    end
  end

  // Grant is suppressed during flush and while reset is asserted
  always_comb begin
    grant_en  = rst && !flush && win_found;
    win_tag   = tag_arr[win_idx];
    win_data  = data_arr[win_idx];
    req_ready = grant_en ? (NREQ'(1) << win_idx) : '0;
  end

  // Next broadcast and pointer; a granted free tag is acknowledged but dropped
  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (flush) begin
      ptr_d = '0;
    end else if (grant_en) begin
      if (win_idx == SRC_W'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx + SRC_W'(1);
      end
      if (win_tag != '0) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = win_tag;
        cdb_data_d  = win_data;
        cdb_src_d   = win_idx;
      end
    end
  end

  // Registered CDB and priority pointer; reset drops any in-flight broadcast
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset/idle, single grant, round-robin order,
// free-tag discard, flush, and asynchronous reset during a broadcast.
module tb_cdb_arbiter;

  localparam int NREQ   = 3;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int SRC_W  = 2;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_data;
  logic [SRC_W-1:0]       cdb_src;

  logic [TAG_W-1:0]  tg [NREQ];
  logic [DATA_W-1:0] dt [NREQ];

  int vec_cnt = 0;
  int err_cnt = 0;

  assign req_tag  = {tg[2], tg[1], tg[0]};
  assign req_data = {dt[2], dt[1], dt[0]};

  cdb_arbiter #(
    .NREQ  (NREQ),
    .TAG_W (TAG_W),
    .DATA_W(DATA_W),
    .SRC_W (SRC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .req_valid(req_valid),
    .req_tag  (req_tag),
    .req_data (req_data),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .cdb_src  (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cdb(input string name, input logic v, input logic [TAG_W-1:0] t,
                           input logic [DATA_W-1:0] d, input logic [SRC_W-1:0] s);
    check_val({name, "_valid"}, 64'(cdb_valid), 64'(v));
    check_val({name, "_tag"},   64'(cdb_tag),   64'(t));
    check_val({name, "_data"},  64'(cdb_data),  64'(d));
    check_val({name, "_src"},   64'(cdb_src),   64'(s));
  endtask

  // Grant order for the fairness run starting from ptr=0
  int rr_order [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    int prev_idx;
    logic [TAG_W-1:0]  prev_tag;
    logic [DATA_W-1:0] prev_data;

    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = 3'b111;
    tg[0] = 4'd1; tg[1] = 4'd2; tg[2] = 4'd3;
    dt[0] = 32'h11; dt[1] = 32'h22; dt[2] = 32'h33;

    // ---- reset held, requests pending: no ready, CDB cleared
    @(negedge clk);
    check_val("rst_ready", 64'(req_ready), 64'd0);
    check_cdb("rst_cdb", 1'b0, 4'd0, 32'd0, 2'd0);
    next_edge();
    next_edge();
    rst       = 1'b1;
    req_valid = 3'b000;

    // ---- idle for 5 cycles
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("idle_ready", 64'(req_ready), 64'd0);
      check_cdb("idle_cdb", 1'b0, 4'd0, 32'd0, 2'd0);
      next_edge();
    end

    // ---- single requester 1, tag 5 data 0x1234
    req_valid = 3'b010; tg[1] = 4'd5; dt[1] = 32'h1234;
    @(negedge clk);
    check_val("single_ready", 64'(req_ready), 64'b010);
    next_edge();
    req_valid = 3'b000;
    @(negedge clk);
    check_cdb("single_cdb", 1'b1, 4'd5, 32'h1234, 2'd1);
    check_val("single_ready_after", 64'(req_ready), 64'd0);
    next_edge();
    @(negedge clk);
    check_val("single_valid_drop", 64'(cdb_valid), 64'd0);
    check_val("single_tag_hold", 64'(cdb_tag), 64'd5);
    next_edge();

    // ---- ptr is 2: grant requester 2 alone so ptr returns to 0
    req_valid = 3'b100; tg[2] = 4'd7; dt[2] = 32'h77;
    @(negedge clk);
    check_val("align_ready", 64'(req_ready), 64'b100);
    next_edge();

    // ---- round-robin: all valid, tags 1/2/3, reload +3 after each grant
    req_valid = 3'b111;
    tg[0] = 4'd1; tg[1] = 4'd2; tg[2] = 4'd3;
    dt[0] = 32'hA001; dt[1] = 32'hA002; dt[2] = 32'hA003;
    prev_idx = 2; prev_tag = 4'd7; prev_data = 32'h77;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_val("rr_ready", 64'(req_ready), 64'(3'b001 << rr_order[c]));
      check_cdb("rr_cdb", 1'b1, prev_tag, prev_data, 2'(prev_idx));
      next_edge();
      prev_idx  = rr_order[c];
      prev_tag  = tg[rr_order[c]];
      prev_data = dt[rr_order[c]];
      tg[rr_order[c]] = tg[rr_order[c]] + 4'd3;
      dt[rr_order[c]] = dt[rr_order[c]] + 32'h10;
    end
    req_valid = 3'b000;
    @(negedge clk);
    check_cdb("rr_last", 1'b1, 4'd6, 32'hA013, 2'd2);
    next_edge();

    // ---- free tag on requester 0: acknowledged, not broadcast, ptr -> 1
    req_valid = 3'b001; tg[0] = 4'd0; dt[0] = 32'hFF;
    @(negedge clk);
    check_val("free_ready", 64'(req_ready), 64'b001);
    next_edge();
    req_valid = 3'b000;
    @(negedge clk);
    check_val("free_valid", 64'(cdb_valid), 64'd0);
    check_val("free_tag_hold", 64'(cdb_tag), 64'd6);
    next_edge();
    req_valid = 3'b011; tg[0] = 4'hA; dt[0] = 32'hAAAA; tg[1] = 4'hB; dt[1] = 32'hBBBB;
    @(negedge clk);
    check_val("free_ptr_ready", 64'(req_ready), 64'b010);
    next_edge();
    req_valid = 3'b001;
    @(negedge clk);
    check_cdb("free_next_cdb", 1'b1, 4'hB, 32'hBBBB, 2'd1);
    check_val("free_next_ready", 64'(req_ready), 64'b001);
    next_edge();
    req_valid = 3'b000;
    @(negedge clk);
    check_cdb("free_next_cdb2", 1'b1, 4'hA, 32'hAAAA, 2'd0);
    next_edge();

    // ---- ptr is 1: grant requester 1 so ptr becomes 2, then flush
    req_valid = 3'b010; tg[1] = 4'hC; dt[1] = 32'hCCCC;
    @(negedge clk);
    check_val("pre_flush_ready", 64'(req_ready), 64'b010);
    next_edge();
    req_valid = 3'b111; flush = 1'b1;
    tg[0] = 4'd1; tg[1] = 4'd2; tg[2] = 4'd3;
    dt[0] = 32'hF1; dt[1] = 32'hF2; dt[2] = 32'hF3;
    @(negedge clk);
    check_val("flush_ready", 64'(req_ready), 64'd0);
    check_cdb("flush_cdb_visible", 1'b1, 4'hC, 32'hCCCC, 2'd1);
    next_edge();
    flush = 1'b0;
    @(negedge clk);
    check_val("post_flush_valid", 64'(cdb_valid), 64'd0);
    check_val("post_flush_ready", 64'(req_ready), 64'b001);
    next_edge();
    req_valid = 3'b110;
    @(negedge clk);
    check_cdb("post_flush_cdb", 1'b1, 4'd1, 32'hF1, 2'd0);
    check_val("post_flush_ready2", 64'(req_ready), 64'b010);
    next_edge();

    // ---- async reset while requester 1's broadcast is on the CDB (ptr is 2)
    req_valid = 3'b100;
    check_cdb("pre_reset_cdb", 1'b1, 4'd2, 32'hF2, 2'd1);
    #2;
    rst = 1'b0;
    #1;
    check_cdb("async_rst_cdb", 1'b0, 4'd0, 32'd0, 2'd0);
    check_val("async_rst_ready", 64'(req_ready), 64'd0);
    next_edge();
    rst = 1'b1;
    req_valid = 3'b110; tg[1] = 4'd5; dt[1] = 32'h55; tg[2] = 4'd6; dt[2] = 32'h66;
    @(negedge clk);
    check_val("after_rst_ready", 64'(req_ready), 64'b010);
    next_edge();
    req_valid = 3'b000;
    @(negedge clk);
    check_cdb("after_rst_cdb", 1'b1, 4'd5, 32'h55, 2'd1);
    next_edge();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
